// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide execute unit (optional MULDIV_EARLY_OUT_EN)
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_noop,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  localparam int B     = BITS_PER_CYCLE;
  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] F7_MUL = 7'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [2*XLEN-1:0]     acc;      // mul: {partial high, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]       opb;      // mul: multiplicand magnitude; div: divisor magnitude
  logic                  op_div;
  logic                  op_hi;    // mul: take the upper half
  logic                  op_rem;   // div: return the remainder
  logic                  neg_main; // negate product / quotient
  logic                  neg_rem;  // negate remainder

  // request decode
  logic                  is_mop;
  logic                  legal;
  logic                  req_div;
  logic                  a_signed;
  logic                  b_signed;
  logic                  sa;
  logic                  sb;
  logic [XLEN-1:0]       mag_a;
  logic [XLEN-1:0]       mag_b;
  logic                  div_zero;
  logic                  div_ovf;
  logic                  early;
  logic                  fast;
  logic [XLEN-1:0]       fast_result;

  // iteration datapath
  logic [2*XLEN-1:0]     acc_next;
  logic [XLEN+B-1:0]     mul_pp;
  logic [XLEN+B-1:0]     mul_sum;
  logic [XLEN-1:0]       div_r;
  logic [XLEN-1:0]       div_q;
  logic [XLEN:0]         div_shift;
  logic [XLEN:0]         div_diff;
  logic [2*XLEN-1:0]     prod_signed;
  logic [XLEN-1:0]       quo_signed;
  logic [XLEN-1:0]       rem_signed;
  logic [XLEN-1:0]       final_result;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // decode the incoming request, its operand magnitudes and any one-cycle result
  always_comb begin
    is_mop   = (in_opcode == OP_REG) && (in_funct7 == F7_MUL);
    legal    = is_mop && !in_noop;
    req_div  = in_funct3[2];
    a_signed = req_div ? !in_funct3[0] : (in_funct3 == 3'd1 || in_funct3 == 3'd2);
    b_signed = req_div ? !in_funct3[0] : (in_funct3 == 3'd1);
    sa       = a_signed && in_rs1_data[XLEN-1];
    sb       = b_signed && in_rs2_data[XLEN-1];
    mag_a    = sa ? -in_rs1_data : in_rs1_data;
    mag_b    = sb ? -in_rs2_data : in_rs2_data;
    div_zero = req_div && (in_rs2_data == '0);
    div_ovf  = req_div && !in_funct3[0] &&
               (in_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2_data == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early    = req_div ? (mag_a < mag_b) : ((in_rs1_data == '0) || (in_rs2_data == '0));
`else
    early    = 1'b0;
`endif
    fast     = div_zero || div_ovf || early;
    fast_result = '0;
    if (div_zero) begin
      fast_result = in_funct3[1] ? in_rs1_data : '1;
    end else if (div_ovf) begin
      fast_result = in_funct3[1] ? '0 : in_rs1_data;
    end else if (early && req_div) begin
      fast_result = in_funct3[1] ? in_rs1_data : '0;
    end
  end

  // one iteration: B shift-add steps for multiply or B restoring steps for divide
  always_comb begin
    mul_pp    = {{B{1'b0}}, opb} * {{XLEN{1'b0}}, acc[B-1:0]};
    mul_sum   = {{B{1'b0}}, acc[2*XLEN-1:XLEN]} + mul_pp;
    div_r     = acc[2*XLEN-1:XLEN];
    div_q     = acc[XLEN-1:0];
    div_shift = '0;
    div_diff  = '0;
    for (int i = 0; i < B; i++) begin
      div_shift = {div_r, div_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opb};
      div_r     = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      div_q     = {div_q[XLEN-2:0], !div_diff[XLEN]};
    end
    acc_next = op_div ? {div_r, div_q} : {mul_sum, acc[XLEN-1:B]};
  end

  // sign correction and result selection applied on the last iteration
  always_comb begin
    prod_signed = neg_main ? -acc_next : acc_next;
    quo_signed  = neg_main ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem_signed  = neg_rem ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    if (op_div) begin
      final_result = op_rem ? rem_signed : quo_signed;
    end else begin
      final_result = op_hi ? prod_signed[2*XLEN-1:XLEN] : prod_signed[XLEN-1:0];
    end
  end

  // control FSM with registered result, tag and illegal flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opb         <= '0;
      op_div      <= 1'b0;
      op_hi       <= 1'b0;
      op_rem      <= 1'b0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_tag <= in_tag;
            if (!legal) begin
              out_result  <= '0;
              out_illegal <= !in_noop;
              state       <= DONE;
            end else if (fast) begin
              out_result  <= fast_result;
              out_illegal <= 1'b0;
              state       <= DONE;
            end else begin
              out_illegal <= 1'b0;
              acc         <= {{XLEN{1'b0}}, (req_div ? mag_a : mag_b)};
              opb         <= req_div ? mag_b : mag_a;
              op_div      <= req_div;
              op_hi       <= (in_funct3[1:0] != 2'd0);
              op_rem      <= in_funct3[1];
              neg_main    <= sa ^ sb;
              neg_rem     <= sa;
              cnt         <= '0;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            out_result <= final_result;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam logic [6:0] OPC = 7'b0110011;
  localparam logic [6:0] F7  = 7'h01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_noop;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_illegal;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] res;
  logic [4:0]  rtag;
  logic        ill;
  int          lat;
  logic        seen;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_noop     (in_noop),
    .in_opcode   (in_opcode),
    .in_funct3   (in_funct3),
    .in_funct7   (in_funct7),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                       input logic noop, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    in_opcode   = opc;
    in_funct7   = f7;
    in_funct3   = f3;
    in_noop     = noop;
    in_rs1_data = a;
    in_rs2_data = b;
    in_tag      = t;
    in_valid    = 1'b1;
  endtask

  task automatic run_op(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                        input logic noop, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, output logic [31:0] r, output logic [4:0] rt,
                        output logic il, output int l);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_before_op", in_ready, 1);
    drive(opc, f7, f3, noop, a, b, t);
    l = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      l++;
    end while (!out_valid && l < 200);
    if (!out_valid) l = 999;
    r  = out_result;
    rt = out_tag;
    il = out_illegal;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(OPC, F7, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    in_valid = 1'b0;

    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", out_result, 0);
    check("rst_tag", out_tag, 0);
    check("rst_illegal", out_illegal, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);

    run_op(OPC, F7, 3'd0, 1'b0, 32'd7, 32'hFFFFFFFD, 5'd3, res, rtag, ill, lat);
    check("mul_res", res, 32'hFFFFFFEB);
    check("mul_lat", lat, 33);
    check("mul_tag", rtag, 5'd3);
    check("mul_ill", ill, 0);

    run_op(OPC, F7, 3'd1, 1'b0, 32'h80000000, 32'h80000000, 5'd4, res, rtag, ill, lat);
    check("mulh_res", res, 32'h40000000);
    check("mulh_lat", lat, 33);
    run_op(OPC, F7, 3'd3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, res, rtag, ill, lat);
    check("mulhu_res", res, 32'hFFFFFFFE);
    run_op(OPC, F7, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd2, 5'd6, res, rtag, ill, lat);
    check("mulhsu_res", res, 32'hFFFFFFFF);
    run_op(OPC, F7, 3'd0, 1'b0, 32'd0, 32'h12345678, 5'd6, res, rtag, ill, lat);
    check("mul_zero_res", res, 32'd0);

    run_op(OPC, F7, 3'd4, 1'b0, 32'hFFFFFFF9, 32'd2, 5'd7, res, rtag, ill, lat);
    check("div_res", res, 32'hFFFFFFFD);
    check("div_lat", lat, 33);
    run_op(OPC, F7, 3'd6, 1'b0, 32'hFFFFFFF9, 32'd2, 5'd8, res, rtag, ill, lat);
    check("rem_res", res, 32'hFFFFFFFF);
    run_op(OPC, F7, 3'd4, 1'b0, 32'd7, 32'hFFFFFFFE, 5'd8, res, rtag, ill, lat);
    check("div_pos_neg", res, 32'hFFFFFFFD);
    run_op(OPC, F7, 3'd6, 1'b0, 32'd7, 32'hFFFFFFFE, 5'd8, res, rtag, ill, lat);
    check("rem_pos_neg", res, 32'd1);
    run_op(OPC, F7, 3'd5, 1'b0, 32'd5, 32'd0, 5'd9, res, rtag, ill, lat);
    check("divu_zero_res", res, 32'hFFFFFFFF);
    check("divu_zero_lat", lat, 1);
    run_op(OPC, F7, 3'd7, 1'b0, 32'd5, 32'd0, 5'd9, res, rtag, ill, lat);
    check("remu_zero_res", res, 32'd5);
    run_op(OPC, F7, 3'd6, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd10, res, rtag, ill, lat);
    check("rem_ovf_res", res, 32'd0);
    check("rem_ovf_lat", lat, 1);
    run_op(OPC, F7, 3'd4, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd11, res, rtag, ill, lat);
    check("div_ovf_res", res, 32'h80000000);
    run_op(OPC, F7, 3'd5, 1'b0, 32'd3, 32'd10, 5'd12, res, rtag, ill, lat);
    check("divu_small_res", res, 32'd0);

    run_op(OPC, 7'h00, 3'd0, 1'b0, 32'd3, 32'd4, 5'd13, res, rtag, ill, lat);
    check("illegal_lat", lat, 1);
    check("illegal_flag", ill, 1);
    check("illegal_res", res, 0);
    check("illegal_tag", rtag, 5'd13);
    run_op(OPC, F7, 3'd0, 1'b1, 32'd3, 32'd4, 5'd14, res, rtag, ill, lat);
    check("noop_lat", lat, 1);
    check("noop_flag", ill, 0);
    check("noop_res", res, 0);

    out_ready = 1'b0;
    run_op(OPC, F7, 3'd5, 1'b0, 32'd100, 32'd7, 5'd15, res, rtag, ill, lat);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_result", out_result, 32'd14);
      check("stall_tag", out_tag, 5'd15);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);

    drive(OPC, F7, 3'd4, 1'b0, 32'd1000, 32'd3, 5'd16);
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_same_cycle_busy", busy, 0);

    drive(OPC, F7, 3'd4, 1'b0, 32'd1000, 32'd3, 5'd17);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= out_valid;
      @(posedge clk); #1;
    end
    check("flush_no_valid", seen, 0);
    run_op(OPC, F7, 3'd5, 1'b0, 32'd100, 32'd7, 5'd21, res, rtag, ill, lat);
    check("after_flush_res", res, 32'd14);
    check("after_flush_tag", rtag, 5'd21);

    drive(OPC, F7, 3'd0, 1'b0, 32'd3, 32'd5, 5'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result", out_result, 0);
    check("midrst_tag", out_tag, 0);
    check("midrst_illegal", out_illegal, 0);
    run_op(OPC, F7, 3'd0, 1'b0, 32'd3, 32'd5, 5'd2, res, rtag, ill, lat);
    check("post_rst_mul", res, 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
